// File: rtl/e_muldiv_unit.sv
// Execute-stage MIPS multiply/divide unit with HI/LO; fixed-latency busy window before commit.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
`timescale 1ns/1ps
module e_muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [63:0]     r_pend, w_pend_nxt;
    logic            r_div0, w_div0_nxt;
    logic [31:0]     r_hi, r_lo, w_hi_nxt, w_lo_nxt;

    logic            w_is_mul, w_is_div, w_sgn, w_acc, w_sub;
    logic [63:0]     w_prod, w_mres;
    logic [31:0]     w_dvd, w_dvs, w_uq, w_ur, w_q, w_r;
    logic            w_neg_q, w_neg_r;

    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_sgn    = 1'b0;
        w_acc    = 1'b0;
        w_sub    = 1'b0;
        case (op)
            OP_MULT:  begin w_is_mul = 1'b1; w_sgn = 1'b1; end
            OP_MULTU: w_is_mul = 1'b1;
            OP_DIV:   begin w_is_div = 1'b1; w_sgn = 1'b1; end
            OP_DIVU:  w_is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_acc = 1'b1; end
            OP_MADDU: begin w_is_mul = 1'b1; w_acc = 1'b1; end
            OP_MSUB:  begin w_is_mul = 1'b1; w_sgn = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            OP_MSUBU: begin w_is_mul = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
`endif
            default:  ;
        endcase
    end

    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    always_comb begin
        if (w_sgn)
            w_prod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        else
            w_prod = {32'd0, rs_val} * {32'd0, rt_val};
        if (w_acc)
            w_mres = w_sub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
        else
            w_mres = w_prod;
    end

    // Signed divide on magnitudes; 0x80000000/-1 naturally yields 0x80000000 rem 0.
    always_comb begin
        w_neg_q = w_sgn & (rs_val[31] ^ rt_val[31]);
        w_neg_r = w_sgn & rs_val[31];
        w_dvd   = (w_sgn && rs_val[31]) ? -rs_val : rs_val;
        w_dvs   = (w_sgn && rt_val[31]) ? -rt_val : rt_val;
        if (w_dvs == 32'd0)
            w_dvs = 32'd1;
        w_uq    = w_dvd / w_dvs;
        w_ur    = w_dvd % w_dvs;
        w_q     = w_neg_q ? -w_uq : w_uq;
        w_r     = w_neg_r ? -w_ur : w_ur;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_div0_nxt  = r_div0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CW'(MULT_CYCLES);
                        w_pend_nxt  = w_mres;
                        w_div0_nxt  = 1'b0;
                    end else if (w_is_div) begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CW'(DIV_CYCLES);
                        w_pend_nxt  = {w_r, w_q};
                        w_div0_nxt  = (rt_val == 32'd0);
                    end else if (op == OP_MTHI) begin
                        w_hi_nxt = rs_val;
                    end else if (op == OP_MTLO) begin
                        w_lo_nxt = rs_val;
                    end
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_IDLE;
                    // A zero divisor runs the full window but leaves HI/LO untouched.
                    if (!r_div0) begin
                        w_hi_nxt = r_pend[63:32];
                        w_lo_nxt = r_pend[31:0];
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_div0  <= w_div0_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Scoreboard bench for e_muldiv_unit: long ops push expected HI/LO/latency, a monitor checks at busy fall.
`timescale 1ns/1ps
module tb_e_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   m_run = 0;
    logic m_prev = 1'b0;

    always #5 clk = ~clk;

    e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts busy-high cycles and checks HI/LO on the cycle busy drops.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            m_run  = 0;
            m_prev = 1'b0;
        end else begin
            if (busy) begin
                m_run++;
            end else if (m_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected commit", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk({m_e.name, " hi"}, hi, m_e.hi);
                    chk({m_e.name, " lo"}, lo, m_e.lo);
                    chk({m_e.name, " busy cycles"}, 32'(m_run), 32'(m_e.len));
                end
                m_run = 0;
            end
            m_prev = busy;
        end
    end

    always @(posedge clk)
        if (reset && start && busy)
            $display("note: start while busy at %0t, op %0d ignored", $time, op);

    task automatic push(input string n, input logic [31:0] h, input logic [31:0] l, input int len);
        exp_t e;
        e.name = n; e.hi = h; e.lo = l; e.len = len;
        sb.push_back(e);
    endtask

    task automatic issue_now(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        issue_now(o, a, b);
    endtask

    task automatic wait_idle(input string n);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk({n, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        #2;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        push("MULT", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle("MULT");
        push("MULTU", 32'h00000002, 32'hFFFFFFFA, 5);
        issue(4'd2, 32'hFFFFFFFE, 32'd3);
        wait_idle("MULTU");

        push("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle("DIV");
        push("DIVU", 32'd1, 32'd3, 10);
        issue(4'd4, 32'd7, 32'd2);
        wait_idle("DIVU");
        push("DIV ovf", 32'd0, 32'h80000000, 10);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle("DIV ovf");

        issue(4'd5, 32'h11, 32'd0);
        chk("MTHI hi", hi, 32'h11);
        chk("MTHI busy", 32'(busy), 32'd0);
        issue(4'd6, 32'h22, 32'd0);
        chk("MTLO lo", lo, 32'h22);
        push("DIV0", 32'h11, 32'h22, 10);
        issue(4'd3, 32'd100, 32'd0);
        wait_idle("DIV0");

        issue(4'd0, 32'hAAAA, 32'hBBBB);
        chk("NONE busy", 32'(busy), 32'd0);
        chk("NONE hi", hi, 32'h11);
        chk("NONE lo", lo, 32'h22);

        push("MULT mt-ignored", 32'd0, 32'd42, 5);
        issue(4'd1, 32'd6, 32'd7);
        @(posedge clk); #1;
        issue_now(4'd6, 32'hDEAD, 32'd0);
        chk("MTLO while busy lo", lo, 32'h22);
        chk("MTLO while busy busy", 32'(busy), 32'd1);
        wait_idle("MULT mt-ignored");
        push("MULT b2b", 32'hFFFFFFFF, 32'hFFFFFFFB, 5);
        issue_now(4'd1, 32'hFFFFFFFF, 32'd5);
        chk("b2b busy rises", 32'(busy), 32'd1);
        wait_idle("MULT b2b");

        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        push("MADDU", 32'd1, 32'd0, 5);
        issue(4'd8, 32'd1, 32'd1);
        chk("MADDU busy", 32'(busy), 32'd1);
        wait_idle("MADDU");
`else
        issue(4'd8, 32'd1, 32'd1);
        chk("op8 disabled busy", 32'(busy), 32'd0);
        chk("op8 disabled hi", hi, 32'd0);
        chk("op8 disabled lo", lo, 32'hFFFFFFFF);
`endif

        issue(4'd5, 32'h55, 32'd0);
        issue(4'd6, 32'h66, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        chk("DIV pre-reset busy", 32'(busy), 32'd1);
        repeat (6) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset hi", hi, 32'd0);
        chk("async reset lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post-reset busy", 32'(busy), 32'd0);
        chk("post-reset hi", hi, 32'd0);
        chk("post-reset lo", lo, 32'd0);

        k = 0;
        while (sb.size() > 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
